// File: rtl/pbits.sv
// pbits: gathers four bit-interleaved lane words, packs them into one 32-bit word and writes it to memory.
// Optional write timeout enabled by defining PBITS_WR_TIMEOUT_EN.
module pbits (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] data_i,
    input  logic [31:0] address_i,
    output logic [31:0] rd_o,
    output logic [31:0] inc_addr_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        wr_start_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    input  logic        wr_done_i,
    output logic        err_o
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANE_W  = 2;
    localparam logic [WORD_W-1:0] ADDR_INC = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   pack_q;
    logic [WORD_W-1:0]   addr_q;
    logic [BYTE_W-1:0]   lane_byte;
    logic                tmo_hit;
    logic                err_q;

    // Pick every fourth bit of the lane word, starting at the current lane.
    always_comb begin
        lane_byte = '0;
        for (int k = 0; k < int'(BYTE_W); k++) begin
            lane_byte[k] = data_i[5'(k * int'(LANES)) + 5'(lane_q)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q <= '0;
            pack_q <= '0;
            addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pack_q[{lane_q, 3'b000} +: BYTE_W] <= lane_byte;
                        if (lane_q == '0) begin
                            addr_q <= address_i;
                        end
                    end
                end
                S_ACK:  lane_q <= lane_q + LANE_W'(1);
                S_DONE: begin
                    lane_q <= '0;
                    pack_q <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef PBITS_WR_TIMEOUT_EN
    localparam int unsigned TMO_W = 8;
    logic [TMO_W-1:0] tmo_q;

    // Counts WAIT cycles; the 256th cycle without an acknowledge aborts the write.
    assign tmo_hit = (state_q == S_WAIT) && !wr_done_i && (tmo_q == {TMO_W{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end else begin
                tmo_q <= '0;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else if (state_q == S_DONE) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_q   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (lane_q == LANE_W'(LANES - 1)) ? S_WRITE : S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_WRITE: state_d = S_WAIT;
            S_WAIT: begin
                if (wr_done_i || tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode the state; everything not valid in a state stays zero.
    always_comb begin
        rd_o       = '0;
        inc_addr_o = '0;
        done_o     = 1'b0;
        wr_start_o = 1'b0;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        err_o      = 1'b0;
        busy_o     = (state_q != S_IDLE);
        case (state_q)
            S_ACK: begin
                done_o = 1'b1;
                rd_o   = pack_q;
            end
            S_WRITE: begin
                wr_start_o = 1'b1;
                wr_addr_o  = addr_q;
                wr_data_o  = pack_q;
            end
            S_WAIT: begin
                wr_addr_o = addr_q;
                wr_data_o = pack_q;
            end
            S_DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
                if (!err_q) begin
                    rd_o       = pack_q;
                    inc_addr_o = ADDR_INC;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pbits.sv
// Randomized scoreboard bench for pbits: a lane-gathering model predicts every done/write pulse.
module tb_pbits;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] data_i;
    logic [31:0] address_i;
    logic [31:0] rd_o;
    logic [31:0] inc_addr_o;
    logic        done_o;
    logic        busy_o;
    logic        wr_start_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        wr_done_i;
    logic        err_o;

    pbits dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .data_i     (data_i),
        .address_i  (address_i),
        .rd_o       (rd_o),
        .inc_addr_o (inc_addr_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .wr_start_o (wr_start_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .wr_done_i  (wr_done_i),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_wr;
        logic [31:0] rd;
        logic [31:0] inc;
        bit          err;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: which lane comes next, the word gathered so far, the sampled address.
    int          lane_m = 0;
    logic [31:0] pack_m = '0;
    logic [31:0] addr_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic exp_t mk_done(input logic [31:0] rd, input logic [31:0] inc, input bit err);
        exp_t e;
        e.is_wr = 1'b0; e.rd = rd; e.inc = inc; e.err = err; e.addr = '0; e.data = '0;
        return e;
    endfunction

    // Monitor: every done/write pulse must match the oldest prediction; idle outputs must be zero.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o || wr_start_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, done_o, wr_start_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, wr_start_o}, {31'd0, e.is_wr});
                    if (e.is_wr) begin
                        check("wr_addr", wr_addr_o, e.addr);
                        check("wr_data", wr_data_o, e.data);
                    end else begin
                        check("rd", rd_o, e.rd);
                        check("inc_addr", inc_addr_o, e.inc);
                        check("err", {31'd0, err_o}, {31'd0, e.err});
                    end
                end
            end
            if (!done_o) begin
                check("idle_result_zero", rd_o | inc_addr_o | {31'd0, err_o}, 32'd0);
            end
            if (!busy_o) begin
                check("idle_write_zero", wr_addr_o | wr_data_o | {31'd0, wr_start_o}, 32'd0);
            end
        end
    end

    // Issue one lane word from IDLE and predict its outcome.
    task automatic send(input logic [31:0] d, input logic [31:0] a);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            b[k] = 1'((d >> (4 * k + lane_m)) & 32'd1);
        end
        if (lane_m == 0) addr_m = a;
        pack_m[lane_m*8 +: 8] = b;
        start_i   = 1'b1;
        data_i    = d;
        address_i = a;
        if (lane_m < 3) begin
            exp_q.push_back(mk_done(pack_m, 32'd0, 1'b0));
            lane_m++;
            tick();
            start_i   = 1'b0;
            data_i    = $urandom;
            address_i = $urandom;
            check("ack_latency", {31'd0, done_o}, 32'd1);
            tick();
        end else begin
            exp_t e;
            e.is_wr = 1'b1; e.rd = '0; e.inc = '0; e.err = 1'b0; e.addr = addr_m; e.data = pack_m;
            exp_q.push_back(e);
            tick();
            start_i   = 1'b0;
            address_i = $urandom;
            begin
                int n = 0;
                while (!wr_start_o && n < 10) begin
                    tick();
                    n++;
                end
                check("wr_start_seen", {31'd0, wr_start_o}, 32'd1);
            end
        end
    endtask

    // Called in the wr_start cycle: acknowledge d cycles later, optionally poking start_i while busy.
    task automatic ack(input int d, input bit poke);
        for (int i = 1; i <= d; i++) begin
            if (poke && i == 2) begin
                start_i = 1'b1;
                data_i  = 32'hFFFF_FFFF;
            end
            tick();
            start_i = 1'b0;
        end
        check("hold_wr_data", wr_data_o, pack_m);
        check("hold_wr_addr", wr_addr_o, addr_m);
        exp_q.push_back(mk_done(pack_m, 32'd4, 1'b0));
        wr_done_i = 1'b1;
        tick();
        wr_done_i = 1'b0;
        lane_m = 0;
        pack_m = '0;
        tick();
    endtask

    task automatic word(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3, input int dly, input bit poke);
        send(d0, a);
        send(d1, $urandom);
        send(d2, $urandom);
        send(d3, $urandom);
        ack(dly, poke);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; data_i = '0; address_i = '0; wr_done_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_outs", rd_o | inc_addr_o | wr_addr_o | wr_data_o, 32'd0);

        // Full pack and bit positions
        word(32'h100, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 32'h8888_8888, 3, 1'b0);
        word(32'h200, 32'h0000_0010, 32'h2000_0000, 32'h0, 32'h0, 1, 1'b0);
        // Busy poke in WAIT, then a fresh word
        word(32'h300, 32'h5555_5555, 32'h0, 32'hAAAA_AAAA, 32'h1, 4, 1'b1);
        word(32'h400, 32'h0000_000F, 32'h0, 32'h0, 32'h0, 2, 1'b0);

        // Reset in the middle of WAIT aborts silently
        send(32'hDEAD_BEEF, 32'h500);
        send(32'h1234_5678, 32'h0);
        send(32'hCAFE_F00D, 32'h0);
        send(32'h0BAD_F00D, 32'h0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        lane_m = 0; pack_m = '0; addr_m = '0;
        check("rst_wait_busy", {31'd0, busy_o}, 32'd0);
        check("rst_wait_done", {31'd0, done_o}, 32'd0);
        tick();
        check("rst_wait_queue", 32'(exp_q.size()), 32'd0);
        word(32'h600, 32'h8888_8888, 32'h1111_1111, 32'h4444_4444, 32'h2222_2222, 2, 1'b0);

        // Randomized words with random gaps, delays and busy pokes
        for (int w = 0; w < 16; w++) begin
            logic [31:0] a;
            a = $urandom;
            for (int l = 0; l < 4; l++) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                send($urandom, (l == 0) ? a : $urandom);
            end
            ack($urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        // Write acknowledge never arrives
        send(32'hFFFF_FFFF, 32'h700);
        send(32'h0, 32'h0);
        send(32'h0, 32'h0);
        send(32'hFFFF_FFFF, 32'h0);
`ifdef PBITS_WR_TIMEOUT_EN
        exp_q.push_back(mk_done(32'd0, 32'd0, 1'b1));
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (!done_o && n < 400);
            check("timeout_cycles", 32'(n), 32'd257);
            check("timeout_err", {31'd0, err_o}, 32'd1);
        end
        tick();
        lane_m = 0; pack_m = '0;
        wr_done_i = 1'b1;
        tick();
        wr_done_i = 1'b0;
        tick();
        check("late_ack_ignored", {31'd0, busy_o}, 32'd0);
`else
        begin
            int busy_cycles = 0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (busy_o) busy_cycles++;
            end
            check("no_timeout_busy", 32'(busy_cycles), 32'd1000);
        end
        exp_q.push_back(mk_done(pack_m, 32'd4, 1'b0));
        wr_done_i = 1'b1;
        tick();
        wr_done_i = 1'b0;
        lane_m = 0; pack_m = '0;
        tick();
`endif
        word(32'h800, 32'h1, 32'h2, 32'h4, 32'h8, 1, 1'b0);

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
